// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter
//   Shares the single SDRAM controller port between the game loader and the
//   NES core. A free-running 2-bit phase counter produces the NES clock
//   enable (run_nes, one clk in four) and the SDRAM slot reference (clkref).
//   Loader bytes are buffered in a small FIFO and committed one per slot,
//   the slot edge being the clk where ph==3. Once loading is done and the
//   FIFO has drained, the port is handed to the NES and reset_nes is released
//   on a slot boundary. Dropping load_done while running returns to loading.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   ld_valid/ld_ready loader byte handshake (ld_addr, ld_data)
//   load_done         loader finished
//   nes_addr, nes_rd_cpu, nes_rd_ppu, nes_wr, nes_dout   NES memory request
//   run_nes           NES clock enable (1 clk in 4)
//   reset_nes         NES reset, low only while the NES owns the port
//   clkref            SDRAM slot reference (ph[1])
//   mem_addr, mem_we, mem_oe_a, mem_oe_b, mem_din        SDRAM port
//                     (mem_we also enables the data-bus driver)
//   load_count        committed loader writes
//
// Configuration
//   MEM_ARB_LOAD_COUNT_EN  when defined, load_count counts loader commits;
//                          otherwise load_count is tied to zero.

module mem_slot_arbiter #(
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data,
  input  logic                 load_done,
  input  logic [ADDR_BITS-1:0] nes_addr,
  input  logic                 nes_rd_cpu,
  input  logic                 nes_rd_ppu,
  input  logic                 nes_wr,
  input  logic [7:0]           nes_dout,
  output logic                 run_nes,
  output logic                 reset_nes,
  output logic                 clkref,
  output logic [ADDR_BITS+2:0] mem_addr,
  output logic                 mem_we,
  output logic                 mem_oe_a,
  output logic                 mem_oe_b,
  output logic [7:0]           mem_din,
  output logic [ADDR_BITS-1:0] load_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned PTR_W = FIFO_AW + 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           data;
  } ld_entry_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           ph;
  logic                 slot_edge;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  ld_entry_t            fifo_mem [DEPTH];
  ld_entry_t            head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 reload_pend;
  logic                 reload_pend_next;
  logic                 reload_req;
  logic                 slot_we;
  logic [ADDR_BITS-1:0] slot_addr;
  logic [7:0]           slot_din;

  // Slot edge: the clk on which ph==3, where loader commits and state changes land
  assign slot_edge = (ph == 2'd3);
  assign clkref    = ph[1];

  // FIFO status; one extra pointer bit separates full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake and FIFO control
  always_comb begin
    state_next       = state;
    reload_pend_next = 1'b0;
    flush            = 1'b0;
    ld_ready         = ~fifo_full & (state != ST_RUN);
    push             = ld_valid & ld_ready;
    pop              = slot_edge & ~fifo_empty & (state != ST_RUN);
    // A low load_done seen at any point in RUN is remembered until the slot edge
    reload_req       = reload_pend | ~load_done;
    unique case (state)
      ST_LOAD: begin
        if (load_done) begin
          if (!fifo_empty) begin
            state_next = ST_DRAIN;
          end else if (slot_edge && !push) begin
            // A byte arriving on this edge must still be written first
            state_next = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_edge && fifo_empty && !push) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (slot_edge && reload_req) begin
          state_next = ST_LOAD;
          flush      = 1'b1;
        end else begin
          reload_pend_next = reload_req;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // Phase counter, clock enable, NES reset and reload tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph          <= 2'd0;
      run_nes     <= 1'b0;
      reset_nes   <= 1'b1;
      reload_pend <= 1'b0;
    end else begin
      ph          <= ph + 2'd1;
      run_nes     <= (ph == 2'd2);
      reset_nes   <= (state_next != ST_RUN);
      reload_pend <= reload_pend_next;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]].addr <= ld_addr;
      fifo_mem[wr_ptr[FIFO_AW-1:0]].data <= ld_data;
    end
  end

  // Loader slot registers: updated only on slot edges, so each write holds 4 clks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_we   <= 1'b0;
      slot_addr <= '0;
      slot_din  <= 8'd0;
    end else if (slot_edge) begin
      slot_we <= pop;
      if (pop) begin
        slot_addr <= head.addr;
        slot_din  <= head.data;
      end
    end
  end

  // Port mux: registered loader slot, or combinational NES passthrough in RUN
  always_comb begin
    mem_addr = {3'b000, slot_addr};
    mem_we   = slot_we;
    mem_din  = slot_din;
    mem_oe_a = 1'b0;
    mem_oe_b = 1'b0;
    if (state == ST_RUN) begin
      mem_addr = {3'b000, nes_addr};
      mem_we   = nes_wr;
      mem_din  = nes_dout;
      mem_oe_a = nes_rd_cpu;
      mem_oe_b = nes_rd_ppu;
    end
  end

`ifdef MEM_ARB_LOAD_COUNT_EN
  logic [ADDR_BITS-1:0] count_q;

  // Commit counter, restarted on every reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + ADDR_BITS'(1);
    end
  end

  assign load_count = count_q;
`else
  assign load_count = '0;
`endif

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter with a queue-based reference model
// compared against every output on every falling clock edge.
module tb_mem_slot_arbiter;

  localparam int unsigned FIFO_AW   = 2;
  localparam int unsigned ADDR_BITS = 22;
  localparam int          DEPTH     = 4;
  localparam int          M_LOAD    = 0;
  localparam int          M_DRAIN   = 1;
  localparam int          M_RUN     = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_BITS-1:0] ld_addr;
  logic [7:0]           ld_data;
  logic                 load_done;
  logic [ADDR_BITS-1:0] nes_addr;
  logic                 nes_rd_cpu;
  logic                 nes_rd_ppu;
  logic                 nes_wr;
  logic [7:0]           nes_dout;
  logic                 run_nes;
  logic                 reset_nes;
  logic                 clkref;
  logic [ADDR_BITS+2:0] mem_addr;
  logic                 mem_we;
  logic                 mem_oe_a;
  logic                 mem_oe_b;
  logic [7:0]           mem_din;
  logic [ADDR_BITS-1:0] load_count;

  int errors = 0;
  int checks = 0;

  mem_slot_arbiter #(.FIFO_AW(FIFO_AW), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .load_done(load_done),
    .nes_addr(nes_addr), .nes_rd_cpu(nes_rd_cpu), .nes_rd_ppu(nes_rd_ppu),
    .nes_wr(nes_wr), .nes_dout(nes_dout),
    .run_nes(run_nes), .reset_nes(reset_nes), .clkref(clkref),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe_a(mem_oe_a), .mem_oe_b(mem_oe_b),
    .mem_din(mem_din), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 100)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                   m_cyc = 0;
  int                   m_mode = M_LOAD;
  bit                   m_reload = 0;
  logic                 m_we = 1'b0;
  logic [ADDR_BITS-1:0] m_addr = '0;
  logic [7:0]           m_din = 8'd0;
  logic [ADDR_BITS-1:0] m_cnt = '0;
  logic [ADDR_BITS+7:0] m_q[$];

  task automatic model_reset();
    m_cyc = 0; m_mode = M_LOAD; m_reload = 0;
    m_we = 1'b0; m_addr = '0; m_din = 8'd0; m_cnt = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    int sz0;
    bit slot;
    bit acc;
    logic [ADDR_BITS+7:0] e;
    sz0  = m_q.size();
    slot = (m_cyc % 4) == 3;
    acc  = ld_valid && (sz0 < DEPTH) && (m_mode != M_RUN);
    if (slot) begin
      if (m_mode != M_RUN && sz0 > 0) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_addr = e[ADDR_BITS+7:8]; m_din = e[7:0];
        m_cnt = m_cnt + ADDR_BITS'(1);
      end else begin
        m_we = 1'b0;
      end
    end
    if (acc) m_q.push_back({ld_addr, ld_data});
    case (m_mode)
      M_LOAD: begin
        if (load_done) begin
          if (sz0 > 0) m_mode = M_DRAIN;
          else if (slot && !acc) m_mode = M_RUN;
        end
      end
      M_DRAIN: if (slot && sz0 == 0 && !acc) m_mode = M_RUN;
      default: begin
        if (!load_done) m_reload = 1;
        if (slot && m_reload) begin
          m_mode = M_LOAD; m_reload = 0; m_q.delete(); m_cnt = '0;
        end
      end
    endcase
    m_cyc++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [ADDR_BITS+2:0] e_addr;
  logic                 e_we, e_oa, e_ob;
  logic [7:0]           e_din;
  logic [ADDR_BITS-1:0] e_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (m_mode == M_RUN) begin
        e_addr = {3'b000, nes_addr}; e_we = nes_wr; e_din = nes_dout;
        e_oa = nes_rd_cpu; e_ob = nes_rd_ppu;
      end else begin
        e_addr = {3'b000, m_addr}; e_we = m_we; e_din = m_din;
        e_oa = 1'b0; e_ob = 1'b0;
      end
`ifdef MEM_ARB_LOAD_COUNT_EN
      e_cnt = m_cnt;
`else
      e_cnt = '0;
`endif
      check("run_nes",    run_nes,    (m_cyc % 4) == 3);
      check("clkref",     clkref,     (m_cyc % 4) >= 2);
      check("reset_nes",  reset_nes,  m_mode != M_RUN);
      check("ld_ready",   ld_ready,   (m_q.size() < DEPTH) && (m_mode != M_RUN));
      check("mem_addr",   mem_addr,   e_addr);
      check("mem_we",     mem_we,     e_we);
      check("mem_din",    mem_din,    e_din);
      check("mem_oe_a",   mem_oe_a,   e_oa);
      check("mem_oe_b",   mem_oe_b,   e_ob);
      check("load_count", load_count, e_cnt);
    end
  end

  // ---------------- loader write log (observed from the DUT) ----------------
  logic                 prev_run = 1'b0;
  logic [ADDR_BITS+7:0] wlog[$];

  always @(negedge clk) begin
    if (!reset && prev_run && mem_we && reset_nes)
      wlog.push_back({mem_addr[ADDR_BITS-1:0], mem_din});
    prev_run = run_nes;
  end

  // ---------------- helpers ----------------
  task automatic go_ph(input int k);
    do begin
      @(posedge clk); #2;
    end while ((m_cyc % 4) != k);
  endtask

  task automatic push_byte(input logic [ADDR_BITS-1:0] a, input logic [7:0] d, output int stalls);
    bit acc;
    int n;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    acc = 0; n = 0;
    while (!acc && n < 64) begin
      @(negedge clk); acc = ld_ready;
      @(posedge clk); #2;
      n++;
    end
    check("push_accept", acc, 1'b1);
    stalls = n - 1;
    ld_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_run_nes",    run_nes,    1'b0);
    check("rst_reset_nes",  reset_nes,  1'b1);
    check("rst_clkref",     clkref,     1'b0);
    check("rst_ld_ready",   ld_ready,   1'b1);
    check("rst_mem_we",     mem_we,     1'b0);
    check("rst_mem_oe_a",   mem_oe_a,   1'b0);
    check("rst_mem_oe_b",   mem_oe_b,   1'b0);
    check("rst_mem_addr",   mem_addr,   25'h0);
    check("rst_mem_din",    mem_din,    8'h0);
    check("rst_load_count", load_count, 22'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit [7:0]             exp_run;
    bit [7:0]             exp_clk;
    int                   stalls;
    int                   drop_at;
    int                   fall_at;
    int                   first_at;
    int                   n;
    int                   wsz;
    logic [ADDR_BITS+7:0] exp_e;

    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = 8'd0; load_done = 1'b0;
    nes_addr = '0; nes_rd_cpu = 1'b0; nes_rd_ppu = 1'b0; nes_wr = 1'b0; nes_dout = 8'd0;

    repeat (3) @(posedge clk);
    #2;
    check_reset_values();
    reset = 1'b0;

    // Free-running phase after release: run_nes on clk 3,7; clkref 0,1,1,0,...
    exp_run = 8'b0100_0100;
    exp_clk = 8'b0110_0110;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      check("lit_run_nes", run_nes, exp_run[i]);
      check("lit_clkref",  clkref,  exp_clk[i]);
      check("lit_idle_we", mem_we,  1'b0);
    end

    // Eight back-to-back bytes, first one offered on a slot edge
    go_ph(3);
    drop_at = -1;
    for (int i = 0; i < 8; i++) begin
      push_byte(ADDR_BITS'(i), 8'(8'hA0 + i), stalls);
      if (stalls > 0 && drop_at < 0) drop_at = i;
    end
    check("lit_ready_drop_after", 32'(drop_at), 32'd4);
    repeat (48) @(posedge clk);
    #2;
    check("lit_wlog_len8", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      exp_e = {ADDR_BITS'(i), 8'(8'hA0 + i)};
      check("lit_wlog_entry", wlog[i], exp_e);
    end
`ifdef MEM_ARB_LOAD_COUNT_EN
    check("lit_load_count8", load_count, 22'd8);
`else
    check("lit_load_count0", load_count, 22'd0);
`endif

    // Three bytes queued, then load_done: drain then hand off
    go_ph(3);
    for (int i = 0; i < 3; i++) push_byte(ADDR_BITS'(32'h100 + i), 8'(8'hC0 + i), stalls);
    load_done = 1'b1;
    fall_at = -1; first_at = -1;
    for (int k = 1; k <= 40 && first_at < 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (!reset_nes && fall_at < 0) fall_at = k;
      if (!reset_nes && run_nes && first_at < 0) first_at = k;
    end
    check("lit_reset_nes_fall", 32'(fall_at), 32'd14);
    check("lit_first_run_nes",  32'(first_at), 32'd17);
    check("lit_wlog_len11", 32'(wlog.size()), 32'd11);

    // NES passthrough
    @(posedge clk); #2;
    nes_addr = 22'h12345; nes_wr = 1'b1; nes_dout = 8'h5A; nes_rd_cpu = 1'b1;
    #1;
    check("lit_pt_addr",  mem_addr, 25'h0012345);
    check("lit_pt_we",    mem_we,   1'b1);
    check("lit_pt_din",   mem_din,  8'h5A);
    check("lit_pt_oe_a",  mem_oe_a, 1'b1);
    check("lit_pt_ready", ld_ready, 1'b0);
    @(posedge clk); #2;
    nes_wr = 1'b0; nes_rd_ppu = 1'b1;
    #1;
    check("lit_pt_oe_b", mem_oe_b, 1'b1);

    // Reload: load_done falls, taken at the next slot edge
    go_ph(0);
    load_done = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (reset_nes) break;
    end
    check("lit_reload_edges", 32'(n), 32'd4);
    check("lit_reload_oe_a",  mem_oe_a, 1'b0);
    check("lit_reload_oe_b",  mem_oe_b, 1'b0);
    check("lit_reload_ready", ld_ready, 1'b1);

    // load_done rise together with a push on an empty FIFO
    @(posedge clk); #2;
    nes_rd_cpu = 1'b0; nes_rd_ppu = 1'b0;
    go_ph(3);
    ld_valid = 1'b1; ld_addr = 22'h3FF; ld_data = 8'hE5; load_done = 1'b1;
    @(posedge clk); #2;
    ld_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("lit_wlog_len12", 32'(wlog.size()), 32'd12);
    check("lit_simul_byte", wlog[wlog.size()-1], {22'h3FF, 8'hE5});
    check("lit_simul_run",  reset_nes, 1'b0);

    // Reset in the middle of a loader write
    @(posedge clk); #2;
    load_done = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    go_ph(3);
    for (int i = 0; i < 4; i++) push_byte(ADDR_BITS'(32'h200 + i), 8'(8'hD0 + i), stalls);
    @(posedge clk); #2;
    check("lit_mid_we",  mem_we,  1'b1);
    check("lit_mid_din", mem_din, 8'hD0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    wsz = wlog.size();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("lit_no_stale_write", 32'(wlog.size()), 32'(wsz));
    check("lit_post_reset_we",  mem_we, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
